// File: rtl/alu_req_sched_if.sv
// ---------------------------------------------------------------------------
// alu_req_sched_if
//   Bundle of the three streams handled by the ALU request scheduler:
//     req_*  : request stream (valid/ready) from the requester
//     alu_*  : issue side (op/a/b/in_valid) and return side (out/out_valid)
//     rsp_*  : response stream (valid/ready) back to the requester
//   Modports:
//     slave  : the scheduler's view
//     master : the environment's view (requester plus ALU)
// ---------------------------------------------------------------------------
interface alu_req_sched_if #(
  parameter int WIDTH = 6
);
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;

  logic [1:0]       alu_op;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic             alu_in_valid;
  logic [WIDTH-1:0] alu_out;
  logic             alu_out_valid;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic [1:0]       rsp_op;

  modport slave (
    input  req_valid, req_op, req_a, req_b,
    input  alu_out, alu_out_valid,
    input  rsp_ready,
    output req_ready,
    output alu_op, alu_a, alu_b, alu_in_valid,
    output rsp_valid, rsp_data, rsp_op
  );

  modport master (
    output req_valid, req_op, req_a, req_b,
    output alu_out, alu_out_valid,
    output rsp_ready,
    input  req_ready,
    input  alu_op, alu_a, alu_b, alu_in_valid,
    input  rsp_valid, rsp_data, rsp_op
  );
endinterface

// File: rtl/alu_req_sched.sv
// ---------------------------------------------------------------------------
// alu_req_sched
//   Requester-side front end for a registered two-stage ALU that cannot
//   stall. Requests are registered onto the ALU inputs, the op travels down
//   a delay line alongside the ALU, and each {op, result} pair is captured
//   into a show-ahead response FIFO with registered outputs. Issue is
//   credit limited: a request is only accepted while the number of
//   accepted-but-not-returned results is below DEPTH, so every ALU result
//   is guaranteed a free FIFO slot.
//
// Parameters:
//   WIDTH   operand/result width (must match the ALU)
//   DEPTH   response FIFO entries, power of two, >= 2
//   ALU_LAT ALU latency from in_valid to out_valid, in cycles
//
// Ports:
//   clk          clock
//   rst_n        asynchronous active-low reset
//   bus          alu_req_sched_if.slave: req_*, alu_*, rsp_* streams
//   err_unexp    sticky: ALU produced a result with nothing in flight
//   chk_mismatch sticky: ALU result differed from the locally computed
//                expected value (present only with the optional checker)
//
// Optional feature macro: ALU_REQ_SCHED_CHECK_EN
//   When defined, an expected-value queue computes add/sub results at
//   accept time and compares them with the ALU result at capture, and the
//   chk_mismatch output is added. When undefined, neither exists.
// ---------------------------------------------------------------------------
module alu_req_sched #(
  parameter int WIDTH   = 6,
  parameter int DEPTH   = 8,
  parameter int ALU_LAT = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_req_sched_if.slave bus,
  output logic           err_unexp
`ifdef ALU_REQ_SCHED_CHECK_EN
  ,
  output logic           chk_mismatch
`endif
);

  localparam int AW = $clog2(DEPTH);       // FIFO pointer width
  localparam int CW = $clog2(DEPTH + 1);   // counts range 0..DEPTH
  localparam int EW = WIDTH + 2;           // FIFO entry: {op, result}

  // ---------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------
  logic             accept;
  logic             pop;
  logic             wr_en;
  logic             unexp;
  logic             bypass;

  logic             req_ready_reg;
  logic [1:0]       alu_op_reg;
  logic [WIDTH-1:0] alu_a_reg;
  logic [WIDTH-1:0] alu_b_reg;
  logic             alu_in_valid_reg;

  logic [1:0]       op_pipe_reg [ALU_LAT];
  logic [1:0]       op_echo;

  logic [CW-1:0]    in_flight_reg;
  logic [CW-1:0]    in_flight_next;
  logic [CW-1:0]    fifo_count_reg;
  logic [CW-1:0]    fifo_count_next;
  logic [CW:0]      outstanding_next;

  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW-1:0]    rd_ptr_next;
  logic [EW-1:0]    mem [DEPTH];
  logic [EW-1:0]    wr_data;
  logic [EW-1:0]    head_next;

  logic             rsp_valid_reg;
  logic [WIDTH-1:0] rsp_data_reg;
  logic [1:0]       rsp_op_reg;
  logic             err_unexp_reg;

  // ---------------------------------------------------------------------
  // Handshakes and capture qualification
  // ---------------------------------------------------------------------
  assign accept  = bus.req_valid & req_ready_reg;
  assign pop     = rsp_valid_reg & bus.rsp_ready;
  // A result arriving with nothing in flight is spurious: it is dropped
  // and flagged rather than allowed to desynchronise the op echo.
  assign wr_en   = bus.alu_out_valid & (in_flight_reg != '0);
  assign unexp   = bus.alu_out_valid & (in_flight_reg == '0);
  assign op_echo = op_pipe_reg[ALU_LAT-1];
  assign wr_data = {op_echo, bus.alu_out};

  // ---------------------------------------------------------------------
  // Next-state for counters, read pointer and FIFO head
  // ---------------------------------------------------------------------
  always_comb begin
    in_flight_next = in_flight_reg;
    if (accept && !wr_en) begin
      in_flight_next = in_flight_reg + 1'b1;
    end else if (!accept && wr_en) begin
      in_flight_next = in_flight_reg - 1'b1;
    end

    fifo_count_next = fifo_count_reg;
    if (wr_en && !pop) begin
      fifo_count_next = fifo_count_reg + 1'b1;
    end else if (!wr_en && pop) begin
      fifo_count_next = fifo_count_reg - 1'b1;
    end

    outstanding_next = {1'b0, in_flight_next} + {1'b0, fifo_count_next};

    rd_ptr_next = pop ? rd_ptr_reg + 1'b1 : rd_ptr_reg;

    // The entry that becomes the head is the one being written right now
    // when the FIFO is (or is about to become) empty; forward it so the
    // response appears one cycle after capture.
    bypass    = wr_en && ((fifo_count_reg == '0) ||
                          ((fifo_count_reg == CW'(1)) && pop));
    head_next = bypass ? wr_data : mem[rd_ptr_next];
  end

  // ---------------------------------------------------------------------
  // Issue registers toward the ALU
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_in_valid_reg <= 1'b0;
      alu_op_reg       <= '0;
      alu_a_reg        <= '0;
      alu_b_reg        <= '0;
    end else begin
      alu_in_valid_reg <= accept;
      if (accept) begin
        alu_op_reg <= bus.req_op;
        alu_a_reg  <= bus.req_a;
        alu_b_reg  <= bus.req_b;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Op echo delay line: free running, so stage ALU_LAT-1 carries the op of
  // the operation whose result is on alu_out in the same cycle.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ALU_LAT; i++) begin
        op_pipe_reg[i] <= '0;
      end
    end else begin
      op_pipe_reg[0] <= alu_op_reg;
      for (int i = 1; i < ALU_LAT; i++) begin
        op_pipe_reg[i] <= op_pipe_reg[i-1];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Credit accounting and request ready
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_flight_reg  <= '0;
      fifo_count_reg <= '0;
      req_ready_reg  <= 1'b1;
    end else begin
      in_flight_reg  <= in_flight_next;
      fifo_count_reg <= fifo_count_next;
      // Registered from next-state counts so ready drops on the very edge
      // that consumes the last credit.
      req_ready_reg  <= (outstanding_next < (CW+1)'(DEPTH));
    end
  end

  // ---------------------------------------------------------------------
  // Response FIFO storage (no reset on the array itself)
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      rd_ptr_reg <= rd_ptr_next;
    end
  end

  // Registered show-ahead output: always holds the head entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= '0;
      rsp_op_reg    <= '0;
    end else begin
      rsp_valid_reg <= (fifo_count_next != '0);
      if (fifo_count_next != '0) begin
        rsp_op_reg   <= head_next[EW-1:WIDTH];
        rsp_data_reg <= head_next[WIDTH-1:0];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Sticky error for spurious ALU results
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_unexp_reg <= 1'b0;
    end else if (unexp) begin
      err_unexp_reg <= 1'b1;
    end
  end

  // The credit rule makes a write into a full FIFO (without a pop in the
  // same cycle) impossible.
  assert property (@(posedge clk) disable iff (!rst_n)
                   !(wr_en && (fifo_count_reg == CW'(DEPTH)) && !pop));

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign bus.req_ready    = req_ready_reg;
  assign bus.alu_op       = alu_op_reg;
  assign bus.alu_a        = alu_a_reg;
  assign bus.alu_b        = alu_b_reg;
  assign bus.alu_in_valid = alu_in_valid_reg;
  assign bus.rsp_valid    = rsp_valid_reg;
  assign bus.rsp_data     = rsp_data_reg;
  assign bus.rsp_op       = rsp_op_reg;
  assign err_unexp        = err_unexp_reg;

`ifdef ALU_REQ_SCHED_CHECK_EN
  // ---------------------------------------------------------------------
  // Expected-value checker. Outstanding in-flight operations never exceed
  // DEPTH, so a DEPTH+ALU_LAT entry ring never overwrites an unread slot.
  // ---------------------------------------------------------------------
  localparam int QD = DEPTH + ALU_LAT;
  localparam int QW = $clog2(QD);

  logic [WIDTH-1:0] exp_mem [QD];
  logic [QW-1:0]    exp_wr_reg;
  logic [QW-1:0]    exp_rd_reg;
  logic [WIDTH-1:0] model_res;
  logic             chk_mismatch_reg;

  always_comb begin
    model_res = '0;
    case (bus.req_op)
      2'd1:    model_res = bus.req_a + bus.req_b;
      2'd2:    model_res = bus.req_a - bus.req_b;
      default: model_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      exp_mem[exp_wr_reg] <= model_res;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_wr_reg       <= '0;
      exp_rd_reg       <= '0;
      chk_mismatch_reg <= 1'b0;
    end else begin
      if (accept) begin
        exp_wr_reg <= (exp_wr_reg == QW'(QD - 1)) ? '0 : exp_wr_reg + 1'b1;
      end
      if (wr_en) begin
        exp_rd_reg <= (exp_rd_reg == QW'(QD - 1)) ? '0 : exp_rd_reg + 1'b1;
        if (bus.alu_out != exp_mem[exp_rd_reg]) begin
          chk_mismatch_reg <= 1'b1;
        end
      end
    end
  end

  assign chk_mismatch = chk_mismatch_reg;
`endif

endmodule

// File: tb/tb_alu_req_sched.sv
// ---------------------------------------------------------------------------
// tb_alu_req_sched
//   Self-checking bench for alu_req_sched. Contains a behavioural two-stage
//   ALU attached to the alu_* side, a reference model that derives each
//   expected response from the request with plain integer arithmetic, and
//   one task per scenario. Build with +define+ALU_REQ_SCHED_CHECK_EN to
//   include the expected-value checker scenario.
// ---------------------------------------------------------------------------
module tb_alu_req_sched;
  localparam int WIDTH   = 6;
  localparam int DEPTH   = 8;
  localparam int ALU_LAT = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic err_unexp;
`ifdef ALU_REQ_SCHED_CHECK_EN
  logic chk_mismatch;
`endif

  int checks   = 0;
  int failures = 0;
  int n_acc    = 0;

  logic [WIDTH+1:0] exp_q[$];
  logic [WIDTH+1:0] got_q[$];

  alu_req_sched_if #(.WIDTH(WIDTH)) bus ();

  alu_req_sched #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ALU_LAT(ALU_LAT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
`ifdef ALU_REQ_SCHED_CHECK_EN
    .chk_mismatch(chk_mismatch),
`endif
    .err_unexp   (err_unexp)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: two register stages, reset from the same rst_n event.
  logic             force_valid  = 1'b0;
  logic [WIDTH-1:0] corrupt_mask = '0;
  logic             s1_v, s2_v;
  logic [1:0]       s1_op;
  logic [WIDTH-1:0] s1_a, s1_b, s2_out;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v <= 1'b0; s2_v <= 1'b0; s1_op <= '0;
      s1_a <= '0; s1_b <= '0; s2_out <= '0;
    end else begin
      s1_v  <= bus.alu_in_valid;
      s1_op <= bus.alu_op;
      s1_a  <= bus.alu_a;
      s1_b  <= bus.alu_b;
      s2_v  <= s1_v;
      case (s1_op)
        2'd1:    s2_out <= s1_a + s1_b;
        2'd2:    s2_out <= s1_a + ~s1_b + 6'd1;
        default: s2_out <= '0;
      endcase
    end
  end

  assign bus.alu_out       = s2_out ^ corrupt_mask;
  assign bus.alu_out_valid = s2_v | force_valid;

  // Reference: response = {op, result mod 2^WIDTH}
  function automatic logic [WIDTH+1:0] ref_rsp(input logic [1:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    int r;
    case (op)
      2'd1:    r = int'(a) + int'(b);
      2'd2:    r = int'(a) - int'(b);
      default: r = 0;
    endcase
    r = r & ((1 << WIDTH) - 1);
    return {op, r[WIDTH-1:0]};
  endfunction

  task automatic drive_req(input logic v);
    bus.req_valid = v;
    bus.req_op    = 2'($urandom_range(0, 3));
    bus.req_a     = WIDTH'($urandom);
    bus.req_b     = WIDTH'($urandom);
  endtask

  // One clock: log handshakes seen before the edge, then step to edge+1.
  task automatic advance();
    bit acc, pp;
    acc = (bus.req_valid === 1'b1) && (bus.req_ready === 1'b1);
    pp  = (bus.rsp_valid === 1'b1) && (bus.rsp_ready === 1'b1);
    if (acc) begin
      exp_q.push_back(ref_rsp(bus.req_op, bus.req_a, bus.req_b));
      n_acc++;
    end
    if (pp) got_q.push_back({bus.rsp_op, bus.rsp_data});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive_req(1'b0);
    bus.rsp_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.alu_in_valid !== 1'b0) begin failures++; $display("FAIL reset_alu_in_valid: got %b want 0", bus.alu_in_valid); end
    checks++;
    if ({bus.alu_op, bus.alu_a, bus.alu_b} !== '0) begin failures++; $display("FAIL reset_alu_bus: got %0h want 0", {bus.alu_op, bus.alu_a, bus.alu_b}); end
    checks++;
    if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
    checks++;
    if ({bus.rsp_op, bus.rsp_data} !== '0) begin failures++; $display("FAIL reset_rsp_data: got %0h want 0", {bus.rsp_op, bus.rsp_data}); end
    checks++;
    if (err_unexp !== 1'b0) begin failures++; $display("FAIL reset_err_unexp: got %b want 0", err_unexp); end
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready: got %b want 1", bus.req_ready); end
    $display("test_reset done");
  endtask

  task automatic test_single_add();
    bus.rsp_ready = 1'b1;
    bus.req_valid = 1'b1; bus.req_op = 2'd1; bus.req_a = 6'd5; bus.req_b = 6'd3;
    advance();                     // accept at edge N; now in cycle N+1
    drive_req(1'b0);
    checks++;
    if (bus.alu_in_valid !== 1'b1 || bus.alu_op !== 2'd1 || bus.alu_a !== 6'd5 || bus.alu_b !== 6'd3) begin
      failures++; $display("FAIL issue_regs: got v=%b op=%0d a=%0d b=%0d want v=1 op=1 a=5 b=3", bus.alu_in_valid, bus.alu_op, bus.alu_a, bus.alu_b);
    end
    for (int k = 1; k <= 3; k++) begin
      checks++;
      if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL latency_early c=N+%0d: rsp_valid got %b want 0", k, bus.rsp_valid); end
      advance();
      if (k == 1) begin
        checks++;
        if (bus.alu_in_valid !== 1'b0 || bus.alu_a !== 6'd5 || bus.alu_op !== 2'd1) begin
          failures++; $display("FAIL issue_hold: got v=%b op=%0d a=%0d want v=0 op=1 a=5", bus.alu_in_valid, bus.alu_op, bus.alu_a);
        end
      end
    end
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 6'd8 || bus.rsp_op !== 2'd1) begin
      failures++; $display("FAIL latency_n4: got v=%b data=%0d op=%0d want v=1 data=8 op=1", bus.rsp_valid, bus.rsp_data, bus.rsp_op);
    end
    advance();
    checks++;
    if (got_q.size() != 1) begin failures++; $display("FAIL single_count: got %0d want 1", got_q.size()); end
    exp_q.delete(); got_q.delete();
    $display("test_single_add done");
  endtask

  task automatic test_ops();
    logic [1:0]       t_op  [4] = '{2'd2, 2'd1, 2'd0, 2'd3};
    logic [WIDTH-1:0] t_a   [4] = '{6'd3, 6'd40, 6'd17, 6'd63};
    logic [WIDTH-1:0] t_b   [4] = '{6'd5, 6'd30, 6'd9, 6'd1};
    logic [WIDTH-1:0] t_exp [4] = '{6'h3E, 6'd6, 6'd0, 6'd0};
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.req_valid = 1'b1; bus.req_op = t_op[i]; bus.req_a = t_a[i]; bus.req_b = t_b[i];
      advance();
    end
    drive_req(1'b0);
    repeat (10) advance();
    checks++;
    if (got_q.size() != 4) begin failures++; $display("FAIL ops_count: got %0d want 4", got_q.size()); end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== {t_op[i], t_exp[i]}) begin
        failures++; $display("FAIL ops[%0d]: got op=%0d data=%0h want op=%0d data=%0h", i, got_q[i][WIDTH+1:WIDTH], got_q[i][WIDTH-1:0], t_op[i], t_exp[i]);
      end
    end
    exp_q.delete(); got_q.delete();
    $display("test_ops done");
  endtask

  task automatic test_fill();
    int  n0, n1;
    bit  seen_ready;
    bus.rsp_ready = 1'b0;
    n0 = n_acc;
    for (int i = 0; i < 12; i++) begin drive_req(1'b1); advance(); end
    checks++;
    if (n_acc - n0 != DEPTH) begin failures++; $display("FAIL fill_accepts: got %0d want %0d", n_acc - n0, DEPTH); end
    checks++;
    if (bus.req_ready !== 1'b0) begin failures++; $display("FAIL fill_ready: got %b want 0", bus.req_ready); end
    for (int i = 0; i < 4; i++) begin drive_req(1'b1); advance(); end
    bus.rsp_ready = 1'b1;
    advance();                     // exactly one pop
    bus.rsp_ready = 1'b0;
    n1 = n_acc;
    seen_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (bus.req_ready === 1'b1) seen_ready = 1'b1;
      drive_req(1'b1);
      advance();
    end
    checks++;
    if (!seen_ready) begin failures++; $display("FAIL refill_ready: req_ready not 1 within 2 cycles of pop"); end
    checks++;
    if (n_acc - n1 != 1) begin failures++; $display("FAIL refill_accepts: got %0d want 1", n_acc - n1); end
    checks++;
    if (bus.req_ready !== 1'b0) begin failures++; $display("FAIL refill_full: got %b want 0", bus.req_ready); end
    drive_req(1'b0);
    bus.rsp_ready = 1'b1;
    repeat (16) advance();
    checks++;
    if (got_q.size() != exp_q.size() || got_q.size() != DEPTH + 1) begin
      failures++; $display("FAIL fill_count: got %0d expected %0d", got_q.size(), DEPTH + 1);
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL fill_rsp[%0d]: got %0h want %0h", i, got_q[i], exp_q[i]); end
    end
    exp_q.delete(); got_q.delete();
    $display("test_fill done");
  endtask

  task automatic test_back_to_back();
    int n0;
    bus.rsp_ready = 1'b1;
    n0 = n_acc;
    for (int i = 0; i < 32; i++) begin drive_req(1'b1); advance(); end
    checks++;
    if (n_acc - n0 != 32) begin failures++; $display("FAIL b2b_accepts: got %0d want 32", n_acc - n0); end
    drive_req(1'b0);
    repeat (10) advance();
    checks++;
    if (got_q.size() != 32) begin failures++; $display("FAIL b2b_count: got %0d want 32", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL b2b_rsp[%0d]: got %0h want %0h", i, got_q[i], exp_q[i]); end
    end
    checks++;
    if (err_unexp !== 1'b0) begin failures++; $display("FAIL b2b_err: got %b want 0", err_unexp); end
    exp_q.delete(); got_q.delete();
    $display("test_back_to_back done");
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      drive_req(1'($urandom_range(0, 1)));
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      advance();
    end
    drive_req(1'b0);
    bus.rsp_ready = 1'b1;
    repeat (DEPTH + 10) advance();
    checks++;
    if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL rand_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL rand_rsp[%0d]: got %0h want %0h", i, got_q[i], exp_q[i]); end
    end
    exp_q.delete(); got_q.delete();
    $display("test_random done");
  endtask

  task automatic test_reset_mid();
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin drive_req(1'b1); advance(); end
    drive_req(1'b0);
    repeat (4) advance();          // first four are now buffered
    for (int i = 0; i < 3; i++) begin drive_req(1'b1); advance(); end
    drive_req(1'b0);               // three in flight
    checks++;
    if (bus.rsp_valid !== 1'b1) begin failures++; $display("FAIL mid_pre_valid: got %b want 1", bus.rsp_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.alu_in_valid !== 1'b0) begin
      failures++; $display("FAIL mid_async: rsp_valid=%b alu_in_valid=%b want 0/0", bus.rsp_valid, bus.alu_in_valid);
    end
    exp_q.delete(); got_q.delete();
    repeat (2) @(posedge clk);
    #4 rst_n = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b1;
    repeat (10) advance();
    checks++;
    if (got_q.size() != 0) begin failures++; $display("FAIL mid_late_rsp: got %0d responses want 0", got_q.size()); end
    checks++;
    if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL mid_ready: got %b want 1", bus.req_ready); end
    exp_q.delete(); got_q.delete();
    $display("test_reset_mid done");
  endtask

`ifdef ALU_REQ_SCHED_CHECK_EN
  task automatic test_check_en();
    checks++;
    if (chk_mismatch !== 1'b0) begin failures++; $display("FAIL chk_pre: got %b want 0", chk_mismatch); end
    bus.rsp_ready = 1'b1;
    corrupt_mask = 6'd1;
    bus.req_valid = 1'b1; bus.req_op = 2'd1; bus.req_a = 6'd5; bus.req_b = 6'd3;
    advance();
    drive_req(1'b0);
    repeat (6) advance();
    corrupt_mask = '0;
    checks++;
    if (chk_mismatch !== 1'b1) begin failures++; $display("FAIL chk_mismatch: got %b want 1", chk_mismatch); end
    exp_q.delete(); got_q.delete();
    $display("test_check_en done");
  endtask
`endif

  task automatic test_err_unexp();
    bus.rsp_ready = 1'b1;
    drive_req(1'b0);
    checks++;
    if (err_unexp !== 1'b0) begin failures++; $display("FAIL err_pre: got %b want 0", err_unexp); end
    force_valid = 1'b1;
    advance();
    force_valid = 1'b0;
    checks++;
    if (err_unexp !== 1'b1) begin failures++; $display("FAIL err_set: got %b want 1", err_unexp); end
    repeat (5) advance();
    checks++;
    if (got_q.size() != 0 || err_unexp !== 1'b1) begin
      failures++; $display("FAIL err_sticky: responses=%0d err=%b want 0/1", got_q.size(), err_unexp);
    end
    drive_req(1'b1);
    advance();
    drive_req(1'b0);
    repeat (8) advance();
    checks++;
    if (got_q.size() != 1) begin failures++; $display("FAIL err_after_count: got %0d want 1", got_q.size()); end
    else begin
      checks++;
      if (got_q[0] !== exp_q[0]) begin failures++; $display("FAIL err_after_rsp: got %0h want %0h", got_q[0], exp_q[0]); end
    end
    exp_q.delete(); got_q.delete();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (err_unexp !== 1'b0) begin failures++; $display("FAIL err_clear: got %b want 0", err_unexp); end
`ifdef ALU_REQ_SCHED_CHECK_EN
    checks++;
    if (chk_mismatch !== 1'b0) begin failures++; $display("FAIL chk_clear: got %b want 0", chk_mismatch); end
`endif
    repeat (2) @(posedge clk);
    #4 rst_n = 1'b1;
    @(posedge clk);
    #1;
    $display("test_err_unexp done");
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_ops();
    test_fill();
    test_back_to_back();
    test_random();
    test_reset_mid();
`ifdef ALU_REQ_SCHED_CHECK_EN
    test_check_en();
`endif
    test_err_unexp();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_req_sched.md
Name: alu_req_sched

Overview:
- Requester-side front end for the registered two-stage ALU.
- Accepts operation requests on a valid/ready stream and drives the ALU's op/a/b/in_valid inputs.
- Captures the ALU's out/out_valid into a response FIFO and returns results on a valid/ready stream with backpressure.
- The ALU cannot stall, so issue is credit-limited so that every result always has a free FIFO slot.

Parameters:
- WIDTH, 6: operand/result width; must match the ALU's WIDTH.
- DEPTH, 8: response FIFO entries; power of two, >=2. Full throughput needs DEPTH>=5.
- ALU_LAT, 2: ALU latency from in_valid to out_valid, in cycles.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset. The top level drives the ALU's rst from ~rst_n.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when req_valid&req_ready at posedge.
- req_op  in  2  operation: 0 nop, 1 add, 2 sub, 3 reserved.
- req_a  in  WIDTH  operand a.
- req_b  in  WIDTH  operand b.
- alu_op  out  2  to ALU op_in.
- alu_a  out  WIDTH  to ALU a_in.
- alu_b  out  WIDTH  to ALU b_in.
- alu_in_valid  out  1  to ALU in_valid.
- alu_out  in  WIDTH  from ALU out.
- alu_out_valid  in  1  from ALU out_valid.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumed when rsp_valid&rsp_ready at posedge.
- rsp_data  out  WIDTH  result.
- rsp_op  out  2  echo of the request op.
- err_unexp  out  1  sticky: alu_out_valid seen with nothing in flight.

Behaviour:
- Reset values (async on rst_n low):
  - alu_in_valid=0, alu_op/alu_a/alu_b=0.
  - rsp_valid=0, rsp_data=0, rsp_op=0, err_unexp=0.
  - FIFO empty, in-flight count 0, op delay line cleared.
  - req_ready=1 after reset release.
- Outstanding count = in_flight + fifo_count, range 0..DEPTH.
- req_ready = (outstanding < DEPTH). It is a registered comparison with no combinational path from rsp_ready.
- Issue:
  - On accept at edge N, alu_* registers load req_* and alu_in_valid=1 during cycle N+1.
  - With no accept, alu_in_valid=0 and alu_op/a/b hold their values.
  - in_flight increments on accept and decrements on alu_out_valid. A simultaneous accept and alu_out_valid leaves it unchanged.
- Op echo: an ALU_LAT-stage delay line of op, advanced every cycle, aligned so its output matches alu_out_valid.
- Capture: when alu_out_valid=1, {op_echo, alu_out} is written into the FIFO at that edge.
  - ALU results are 0 for nop and reserved ops; these are still captured and returned.
- Latency: accept at edge N, rsp_valid=1 in cycle N+4 when the FIFO is empty.
  - Path: alu_in_valid N+1, ALU output N+3, FIFO write at edge N+3.
- FIFO: registered output, show-ahead. rsp_* present the head entry while rsp_valid=1.
  - Pop on rsp_valid&rsp_ready.
  - Simultaneous write and pop when full or empty is legal; count is unchanged by a write plus a pop.
  - Pointers wrap modulo DEPTH.
- Ordering: responses are returned strictly in acceptance order.
- Arithmetic: none performed locally. rsp_data is exactly WIDTH bits, wrap-around as produced by the ALU.
- Errors:
  - alu_out_valid while in_flight=0: the write is dropped and err_unexp is set until reset.
  - A FIFO write while full cannot occur under the credit rule; an assertion checks it.
- Reset mid-operation: in-flight and buffered results are discarded with no late responses. The ALU is reset by the same event.
- Request stability: req_* may change freely while req_ready=0. No X-propagation on req_* when req_valid=0.

Optional Feature:
- Macro: ALU_REQ_SCHED_CHECK_EN
- Defined:
  - An internal DEPTH+ALU_LAT-entry expected-value queue stores the model result at accept: add a+b, sub a-b, each mod 2^WIDTH, else 0.
  - At capture, the ALU result is compared against the queue head.
  - Adds output chk_mismatch (1 bit), sticky, reset 0, set on the first difference.
- Not defined: no queue, no chk_mismatch port; behaviour otherwise identical.

Test Plan:
- Single add a=5,b=3 accepted at edge N, rsp_ready=1 -> rsp_valid in cycle N+4 with rsp_data=8, rsp_op=1.
- Sub a=3,b=5 -> rsp_data=6'h3E. Add a=40,b=30 -> rsp_data=6 (wrap). nop and op=3 -> rsp_data=0 with op echoed.
- rsp_ready=0, req_valid held for 12 cycles -> exactly 8 accepted and req_ready=0. One pop -> req_ready=1 two cycles later, one more accept, order preserved.
- Back-to-back 32 requests with rsp_ready=1, DEPTH=8 -> one accept per cycle, 32 in-order responses, err_unexp=0.
- rst_n pulsed low with 3 in flight and 4 buffered -> rsp_valid=0 immediately, no responses after release, req_ready=1.
- alu_out_valid forced high with in_flight=0 -> err_unexp=1 and sticky, FIFO count unchanged. With CHECK_EN, a corrupted alu_out -> chk_mismatch=1.
